// File: rtl/link_tx_sync.sv
// link_tx_sync: clocked sender into the asynchronous multi-rail link fabric.
// Each accepted word is driven as WIDTH rail pairs, either two-phase
// level-encoded (ENC="TP") or four-phase return-to-zero (ENC="FP"). The
// transmitter then waits for the per-bit completion acks, which are
// synchronised before any decision is taken on them.
// Optional macro LINK_TX_TIMEOUT_EN adds a sticky ack-timeout flag on err.
module link_tx_sync #(
    parameter int          WIDTH       = 8,
    parameter logic [15:0] ENC         = "TP",
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [2*WIDTH-1:0]   link_data,
    input  logic [WIDTH-1:0]     link_ack,
    output logic                 busy,
    output logic                 err
);

    localparam bit IS_FP = (ENC == "FP");
    localparam bit IS_TP = (ENC == "TP");

    generate
        if (!IS_FP && !IS_TP) begin : g_bad_enc
            $error("link_tx_sync: ENC must be \"TP\" or \"FP\"");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("link_tx_sync: SYNC_STAGES must be at least 2");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("link_tx_sync: TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_WAIT_RTZ = 2'd2
    } state_t;

    state_t                              r_state;
    logic [2*WIDTH-1:0]                  r_link;
    logic                                r_phase;
    logic                                r_ready;
    logic                                r_busy;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   r_sync;

    logic [WIDTH-1:0]                    w_ack_s;
    logic                                w_all_one;
    logic                                w_all_zero;
    logic                                w_tp_done;
    logic                                w_accept;
    logic [2*WIDTH-1:0]                  w_enc;

    // Ack synchroniser: each ack bit crosses SYNC_STAGES flops before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], link_ack};
        end
    end

    assign w_ack_s    = r_sync[SYNC_STAGES-1];
    assign w_all_one  = &w_ack_s;
    assign w_all_zero = ~|w_ack_s;
    // In TP the pair XOR seen by a cell equals the phase of the token in flight.
    assign w_tp_done  = (w_ack_s == {WIDTH{r_phase}});
    assign w_accept   = (r_state == S_IDLE) && r_ready && in_valid;

    // Rail encoding of in_data; in TP the false rail uses the phase the token will carry.
    always_comb begin
        w_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_enc[2*i+1] = in_data[i];
            if (IS_FP) begin
                w_enc[2*i] = ~in_data[i];
            end else begin
                w_enc[2*i] = in_data[i] ^ ~r_phase;
            end
        end
    end

    // Handshake state machine with registered rails, ready and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_link  <= '0;
            r_phase <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_link  <= w_enc;
                        r_phase <= IS_FP ? r_phase : ~r_phase;
                        r_state <= S_WAIT_ACK;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_WAIT_ACK: begin
                    if (IS_FP) begin
                        if (w_all_one) begin
                            r_link  <= '0;
                            r_state <= S_WAIT_RTZ;
                        end
                    end else if (w_tp_done) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_WAIT_RTZ: begin
                    if (w_all_zero) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_link  <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign link_data = r_link;
    assign in_ready  = r_ready;
    assign busy      = r_busy;

`ifdef LINK_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_tcnt;
    logic          r_err;
    logic          w_advance;

    // Any state transition is a state entry and restarts the wait count.
    always_comb begin
        w_advance = 1'b0;
        case (r_state)
            S_IDLE:     w_advance = w_accept;
            S_WAIT_ACK: w_advance = IS_FP ? w_all_one : w_tp_done;
            S_WAIT_RTZ: w_advance = w_all_zero;
            default:    w_advance = 1'b1;
        endcase
    end

    // Saturating wait counter and sticky timeout flag; the FSM never aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else if (w_advance || (r_state == S_IDLE)) begin
            r_tcnt <= '0;
        end else if (r_tcnt != CW'(TIMEOUT)) begin
            r_tcnt <= r_tcnt + CW'(1);
            if (r_tcnt == CW'(TIMEOUT - 1)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_link_tx_sync.sv
// Bench for link_tx_sync: one TP and one FP instance (WIDTH=4), a downstream
// cell model that acks with the XOR of each rail pair, and a reference model
// of the rail encoding and handshake timing derived from the protocol rules.
module tb_link_tx_sync;

    localparam int W  = 4;
    localparam int SS = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tp_valid, tp_ready, tp_busy, tp_err;
    logic [W-1:0]   tp_data, tp_ack;
    logic [2*W-1:0] tp_link;
    logic           fp_valid, fp_ready, fp_busy, fp_err;
    logic [W-1:0]   fp_data, fp_ack;
    logic [2*W-1:0] fp_link;

    int             n_vec = 0;
    int             n_bad = 0;
    bit             exp_phase;
    logic [2*W-1:0] last_tp;
    logic [2*W-1:0] obs_rails;

    always #5 clk = ~clk;

    link_tx_sync #(.WIDTH(W), .ENC("TP"), .SYNC_STAGES(SS), .TIMEOUT(16)) u_tp (
        .clk(clk), .rst_n(rst_n), .in_valid(tp_valid), .in_ready(tp_ready),
        .in_data(tp_data), .link_data(tp_link), .link_ack(tp_ack),
        .busy(tp_busy), .err(tp_err));

    link_tx_sync #(.WIDTH(W), .ENC("FP"), .SYNC_STAGES(SS), .TIMEOUT(16)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(fp_valid), .in_ready(fp_ready),
        .in_data(fp_data), .link_data(fp_link), .link_ack(fp_ack),
        .busy(fp_busy), .err(fp_err));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding: true rail = bit; false rail = ~bit (FP) or bit^phase (TP).
    function automatic logic [2*W-1:0] enc_word(input bit fp, input logic [W-1:0] b, input bit ph);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[2*i+1] = b[i];
            r[2*i]   = fp ? ~b[i] : (b[i] ^ ph);
        end
        return r;
    endfunction

    // Downstream cell model: each ack is the XOR of its rail pair.
    function automatic logic [W-1:0] pair_xor(input logic [2*W-1:0] r);
        logic [W-1:0] a;
        for (int i = 0; i < W; i++) a[i] = r[2*i+1] ^ r[2*i];
        return a;
    endfunction

    function automatic logic get_ready(input bit fp); return fp ? fp_ready : tp_ready; endfunction
    function automatic logic get_busy(input bit fp);  return fp ? fp_busy  : tp_busy;  endfunction
    function automatic logic get_err(input bit fp);   return fp ? fp_err   : tp_err;   endfunction
    function automatic logic [2*W-1:0] get_link(input bit fp); return fp ? fp_link : tp_link; endfunction

    task automatic drive_in(input bit fp, input logic v, input logic [W-1:0] d);
        if (fp) begin fp_valid = v; fp_data = d; end
        else begin tp_valid = v; tp_data = d; end
    endtask

    task automatic drive_ack(input bit fp, input logic [W-1:0] a);
        if (fp) fp_ack = a;
        else tp_ack = a;
    endtask

    // After the ack settles: SS edges with nothing visible, then the step on edge SS+1.
    task automatic expect_after_ack(input bit fp, input logic [2*W-1:0] now_r,
                                    input logic [2*W-1:0] next_r, input bit to_idle, input string tag);
        for (int k = 1; k <= SS + 1; k++) begin
            @(posedge clk); #1;
            if (k <= SS) begin
                check_val({tag, "_early_ready"}, get_ready(fp), 1'b0);
                check_val({tag, "_early_rails"}, get_link(fp), now_r);
            end else begin
                check_val({tag, "_ready"}, get_ready(fp), to_idle);
                check_val({tag, "_busy"}, get_busy(fp), !to_idle);
                check_val({tag, "_rails"}, get_link(fp), next_r);
            end
        end
    endtask

    task automatic send_token(input bit fp, input logic [W-1:0] word, input int dly,
                              input bit partial, input bit hold, input logic [W-1:0] nxt);
        logic [2*W-1:0] er;
        logic [2*W-1:0] d;
        int waited;
        waited = 0;
        while (get_ready(fp) !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check_val("ready_before_send", get_ready(fp), 1'b1);
        drive_in(fp, 1'b1, word);
        @(posedge clk); #1;
        if (!fp) exp_phase = ~exp_phase;
        er = enc_word(fp, word, exp_phase);
        obs_rails = get_link(fp);
        check_val("rails_on_accept", obs_rails, er);
        check_val("busy_on_accept", get_busy(fp), 1'b1);
        check_val("ready_drop", get_ready(fp), 1'b0);
        if (!fp) begin
            d = last_tp ^ obs_rails;
            for (int i = 0; i < W; i++)
                check_val("one_rail_toggles", {1'b0, d[2*i+1]} + {1'b0, d[2*i]}, 2'd1);
            last_tp = obs_rails;
        end
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            drive_in(fp, hold, W'($urandom));
            check_val("rails_hold", get_link(fp), er);
            check_val("ready_wait", get_ready(fp), 1'b0);
        end
        @(negedge clk);
        if (partial) begin
            drive_ack(fp, pair_xor(er) ^ 4'b1000);
            repeat (50) @(negedge clk);
            check_val("partial_ready", get_ready(fp), 1'b0);
            check_val("partial_busy", get_busy(fp), 1'b1);
            check_val("partial_rails", get_link(fp), er);
        end
        drive_ack(fp, pair_xor(er));
        drive_in(fp, hold, hold ? nxt : W'($urandom));
        expect_after_ack(fp, er, fp ? '0 : er, !fp, "data_ack");
        if (fp) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            @(negedge clk);
            check_val("spacer_hold", get_link(fp), 8'h00);
            drive_ack(fp, '0);
            expect_after_ack(fp, '0, '0, 1'b1, "rtz_ack");
        end
`ifndef LINK_TX_TIMEOUT_EN
        check_val("err_low", get_err(fp), 1'b0);
`endif
    endtask

    task automatic assert_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        drive_in(1'b0, 1'b0, '0);
        drive_in(1'b1, 1'b0, '0);
        tp_ack = '0;
        fp_ack = '0;
        exp_phase = 1'b0;
        last_tp = '0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("ready_after_release_tp", tp_ready, 1'b1);
        check_val("ready_after_release_fp", fp_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        tp_valid = 1'b0; fp_valid = 1'b0;
        tp_data = '0; fp_data = '0;
        tp_ack = '0; fp_ack = '0;
        exp_phase = 1'b0;
        last_tp = '0;
        obs_rails = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rails_tp", tp_link, 8'h00);
        check_val("rst_rails_fp", fp_link, 8'h00);
        check_val("rst_ready_tp", tp_ready, 1'b0);
        check_val("rst_ready_fp", fp_ready, 1'b0);
        check_val("rst_busy_tp", tp_busy, 1'b0);
        check_val("rst_err_tp", tp_err, 1'b0);
        release_reset();

        send_token(1'b0, 4'hA, 3, 1'b0, 1'b0, 4'h0);
        check_val("tp_A_rails", obs_rails, 8'b10_01_10_01);
        send_token(1'b0, 4'h5, 2, 1'b0, 1'b1, 4'h5);
        check_val("tp_5a_rails", obs_rails, 8'b00_11_00_11);
        send_token(1'b0, 4'h5, 2, 1'b0, 1'b0, 4'h0);
        check_val("tp_5b_rails", obs_rails, 8'b01_10_01_10);
        send_token(1'b1, 4'h3, 2, 1'b0, 1'b0, 4'h0);
        check_val("fp_3_rails", obs_rails, 8'b01_01_10_10);
        send_token(1'b0, 4'h9, 1, 1'b1, 1'b0, 4'h0);

        // Reset mid-token: rails and busy must drop without waiting for a clock.
        drive_in(1'b0, 1'b1, 4'h6);
        @(posedge clk); #1;
        drive_in(1'b0, 1'b0, 4'h0);
        check_val("pre_reset_busy", tp_busy, 1'b1);
        assert_reset();
        check_val("async_rst_rails", tp_link, 8'h00);
        check_val("async_rst_busy", tp_busy, 1'b0);
        check_val("async_rst_ready", tp_ready, 1'b0);
        release_reset();

        for (int n = 0; n < 30; n++) begin
            send_token(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 6),
                       ($urandom_range(0, 7) == 0), 1'b0, 4'h0);
        end

`ifdef LINK_TX_TIMEOUT_EN
        assert_reset();
        release_reset();
        check_val("err_clear_after_reset", tp_err, 1'b0);
        drive_in(1'b0, 1'b1, W'($urandom));
        @(posedge clk); #1;
        drive_in(1'b0, 1'b0, 4'h0);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            check_val("timeout_err", tp_err, (k >= 16));
        end
        check_val("timeout_still_waiting", tp_busy, 1'b1);
        assert_reset();
        check_val("timeout_err_reset", tp_err, 1'b0);
        release_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
